// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the parametrised register file with scoreboard.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h1fff;

  typedef logic [AW_DEFAULT-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle of the register file: read ports, write port, issue and clear.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NRD  = 2,
  parameter int AW   = AW_DEFAULT
);
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                stall;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb_clr;
  logic [AW-1:0]       wb_rd;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_rd, wb_clr, wb_rd,
    input  rdata, rbusy, stall
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_rd, wb_clr, wb_rd,
    output rdata, rbusy, stall
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits: set on long-latency issue, cleared on writeback, looked up per read port.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_clr,
  input  logic [AW-1:0]     wb_rd,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first so a same-register issue overrides it: the new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) busy_d[wb_rd] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_look
    assign rbusy[i] = busy_q[raddr[i*AW +: AW]];
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with RAW scoreboard; x0 hardwired to zero.
// Optional write-first bypass of data and busy under macro REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int          XLEN    = XLEN_DEFAULT,
  parameter int          NREGS   = NREGS_DEFAULT,
  parameter int          NRD     = 2,
  parameter int          SP_IDX  = REG_SP,
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT,
  localparam int         AW      = $clog2(NREGS)
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rdata_c;
  logic [NRD-1:0]      rbusy_q;
  logic [NRD-1:0]      rbusy_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= (r == SP_IDX) ? XLEN'(SP_INIT) : '0;
    end else if (bus.we && bus.waddr != '0) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wb_clr    (bus.wb_clr),
    .wb_rd     (bus.wb_rd),
    .raddr     (bus.raddr),
    .rbusy     (rbusy_q)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit_w;
    assign ra = bus.raddr[i*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
    assign hit_w = !reset && bus.we && (bus.waddr == ra) && (ra != '0);
`else
    assign hit_w = 1'b0;
`endif
    assign rdata_c[i*XLEN +: XLEN] = (ra == '0) ? '0 : (hit_w ? bus.wdata : regs[ra]);
    // A forwarded writeback retires the hazard early unless a new producer claims the register.
    assign rbusy_c[i] = rbusy_q[i] &&
                        !(hit_w && bus.wb_clr && (bus.wb_rd == ra) &&
                          !(bus.iss_valid && bus.iss_rd == ra));
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;
  assign bus.stall = |rbusy_c;
endmodule
